hsv_conv_sched: RTL and testbench

- Sequencer that feeds camera RGB555-in-16-bit pixels, one at a time, into the shared rgb2hsv converter.
- Aligns each issue with the converter's four-cycle FETCH→COMPARE→SETDIV→DIVIDE loop and captures the HSV result.
- Tags each result with pixel x/y coordinates and a ball-colour match flag.
- Sits between the camera capture stream and the ball-position logic.

---
 rtl/hsv_conv_sched.sv | 227 ++++++++++++++++++++++
 tb/tb_hsv_conv_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/hsv_conv_sched.sv
// Sequencer feeding camera RGB555 pixels into the shared rgb2hsv converter and tagging results.
// Optional macro HSV_SCHED_MATCH_COUNT_EN adds per-frame match counting (frame_match_cnt, frame_end).
module hsv_conv_sched #(
    parameter int         WIDTH    = 640,
    parameter int         HEIGHT   = 480,
    parameter int         CONV_LAT = 4,
    parameter logic [6:0] HUE_LO   = 7'd0,
    parameter logic [6:0] HUE_HI   = 7'd10,
    parameter logic [4:0] SAT_MIN  = 5'd8,
    parameter logic [4:0] VAL_MIN  = 5'd6
) (
    input  logic        clk,
    input  logic        res,
    input  logic        pix_valid,
    input  logic [15:0] pix_data,
    input  logic        pix_sof,
    input  logic        pix_eol,
    output logic        pix_ready,
    output logic        conv_res,
    output logic        conv_read,
    output logic [15:0] conv_data,
    input  logic [6:0]  conv_hue,
    input  logic [4:0]  conv_sat,
    input  logic [4:0]  conv_val,
    input  logic        conv_hue_invalid,
    input  logic        conv_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [6:0]  out_hue,
    output logic [4:0]  out_sat,
    output logic [4:0]  out_val,
    output logic [9:0]  out_x,
    output logic [8:0]  out_y,
    output logic        out_match
`ifdef HSV_SCHED_MATCH_COUNT_EN
    ,
    output logic [18:0] frame_match_cnt,
    output logic        frame_end
`endif
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_OUTPUT = 2'd3;

    localparam logic [9:0] X_MAX    = 10'(WIDTH - 1);
    localparam logic [8:0] Y_MAX    = 9'(HEIGHT - 1);
    localparam logic [7:0] CNT_LAST = 8'(CONV_LAT - 1);
    localparam logic       HUE_WRAP = (HUE_LO > HUE_HI);

    logic [1:0]  state_q, state_d;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic [9:0]  cur_x_q, cur_x_d;
    logic [8:0]  cur_y_q, cur_y_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] conv_data_q, conv_data_d;
    logic        conv_res_q, conv_res_d;
    logic [6:0]  hue_q, hue_d;
    logic [4:0]  sat_q, sat_d;
    logic [4:0]  val_q, val_d;
    logic [9:0]  ox_q, ox_d;
    logic [8:0]  oy_q, oy_d;
    logic        match_q, match_d;

    logic        accept;
    logic [9:0]  acc_x;
    logic [8:0]  acc_y;

    // Threshold tests via sign of a widened difference so zero bounds stay non-constant compares.
    logic [7:0]  hue_lo_diff, hue_hi_diff;
    logic [5:0]  sat_diff, val_diff;
    logic        hue_in_win, match_now;

    assign hue_lo_diff = {1'b0, conv_hue} - {1'b0, HUE_LO};
    assign hue_hi_diff = {1'b0, HUE_HI} - {1'b0, conv_hue};
    assign sat_diff    = {1'b0, conv_sat} - {1'b0, SAT_MIN};
    assign val_diff    = {1'b0, conv_val} - {1'b0, VAL_MIN};
    assign hue_in_win  = HUE_WRAP ? (!hue_lo_diff[7] || !hue_hi_diff[7])
                                  : (!hue_lo_diff[7] && !hue_hi_diff[7]);
    assign match_now   = !conv_hue_invalid && hue_in_win && !sat_diff[5] && !val_diff[5];

    assign pix_ready = (state_q == S_IDLE) && !conv_res_q;
    assign accept    = pix_valid && pix_ready;
    assign acc_x     = pix_sof ? 10'd0 : x_q;
    assign acc_y     = pix_sof ? 9'd0 : y_q;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        cur_x_d     = cur_x_q;
        cur_y_d     = cur_y_q;
        cnt_d       = cnt_q;
        conv_data_d = conv_data_q;
        conv_res_d  = 1'b0;
        hue_d       = hue_q;
        sat_d       = sat_q;
        val_d       = val_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        match_d     = match_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    conv_data_d = pix_data;
                    cur_x_d     = acc_x;
                    cur_y_d     = acc_y;
                    if (pix_eol || acc_x == X_MAX) begin
                        x_d = 10'd0;
                        y_d = (acc_y == Y_MAX) ? acc_y : acc_y + 9'd1;
                    end else begin
                        x_d = acc_x + 10'd1;
                        y_d = acc_y;
                    end
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (conv_done || cnt_q == CNT_LAST) begin
                    hue_d   = conv_hue;
                    sat_d   = conv_sat;
                    val_d   = conv_val;
                    ox_d    = cur_x_q;
                    oy_d    = cur_y_q;
                    match_d = match_now;
                    state_d = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q     <= S_IDLE;
            x_q         <= 10'd0;
            y_q         <= 9'd0;
            cur_x_q     <= 10'd0;
            cur_y_q     <= 9'd0;
            cnt_q       <= 8'd0;
            conv_data_q <= 16'd0;
            conv_res_q  <= 1'b1;
            hue_q       <= 7'd0;
            sat_q       <= 5'd0;
            val_q       <= 5'd0;
            ox_q        <= 10'd0;
            oy_q        <= 9'd0;
            match_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            cur_x_q     <= cur_x_d;
            cur_y_q     <= cur_y_d;
            cnt_q       <= cnt_d;
            conv_data_q <= conv_data_d;
            conv_res_q  <= conv_res_d;
            hue_q       <= hue_d;
            sat_q       <= sat_d;
            val_q       <= val_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            match_q     <= match_d;
        end
    end

    assign conv_res  = conv_res_q;
    assign conv_read = (state_q == S_ISSUE);
    assign conv_data = conv_data_q;
    assign out_valid = (state_q == S_OUTPUT);
    assign out_hue   = hue_q;
    assign out_sat   = sat_q;
    assign out_val   = val_q;
    assign out_x     = ox_q;
    assign out_y     = oy_q;
    assign out_match = match_q;

`ifdef HSV_SCHED_MATCH_COUNT_EN
    logic [18:0] mcnt_q, mcnt_d;
    logic [18:0] fcnt_q, fcnt_d;
    logic        fend_q, fend_d;
    logic [18:0] mcnt_inc;
    logic        sof_accept;

    // A match handshake coinciding with the sof acceptance lands in the snapshot, not the new frame.
    assign sof_accept = accept && pix_sof;
    assign mcnt_inc   = mcnt_q + {18'd0, (out_valid && out_ready && match_q)};

    always_comb begin
        mcnt_d = mcnt_inc;
        fcnt_d = fcnt_q;
        fend_d = sof_accept;
        if (sof_accept) begin
            fcnt_d = mcnt_inc;
            mcnt_d = 19'd0;
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            mcnt_q <= 19'd0;
            fcnt_q <= 19'd0;
            fend_q <= 1'b0;
        end else begin
            mcnt_q <= mcnt_d;
            fcnt_q <= fcnt_d;
            fend_q <= fend_d;
        end
    end

    assign frame_match_cnt = fcnt_q;
    assign frame_end       = fend_q;
`endif

endmodule

// File: tb/tb_hsv_conv_sched.sv
// Bench for hsv_conv_sched: two instances (default and small-frame/wrapped-hue) driven in lockstep.
module tb_hsv_conv_sched;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        pix_valid = 1'b0;
    logic [15:0] pix_data = 16'd0;
    logic        pix_sof = 1'b0;
    logic        pix_eol = 1'b0;
    logic [6:0]  conv_hue = 7'd0;
    logic [4:0]  conv_sat = 5'd0;
    logic [4:0]  conv_val = 5'd0;
    logic        conv_hue_invalid = 1'b0;
    logic        conv_done = 1'b0;
    logic        out_ready = 1'b0;

    logic        a_pix_ready, a_conv_res, a_conv_read, a_out_valid, a_out_match;
    logic [15:0] a_conv_data;
    logic [6:0]  a_out_hue;
    logic [4:0]  a_out_sat, a_out_val;
    logic [9:0]  a_out_x;
    logic [8:0]  a_out_y;
    logic        b_pix_ready, b_conv_res, b_conv_read, b_out_valid, b_out_match;
    logic [15:0] b_conv_data;
    logic [6:0]  b_out_hue;
    logic [4:0]  b_out_sat, b_out_val;
    logic [9:0]  b_out_x;
    logic [8:0]  b_out_y;
`ifdef HSV_SCHED_MATCH_COUNT_EN
    logic [18:0] a_fmc, b_fmc;
    logic        a_fend, b_fend;
`endif

    localparam int CONV_LAT = 4;

    hsv_conv_sched dut_a (
        .clk(clk), .res(res), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_ready(a_pix_ready),
        .conv_res(a_conv_res), .conv_read(a_conv_read), .conv_data(a_conv_data),
        .conv_hue(conv_hue), .conv_sat(conv_sat), .conv_val(conv_val),
        .conv_hue_invalid(conv_hue_invalid), .conv_done(conv_done),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_hue(a_out_hue),
        .out_sat(a_out_sat), .out_val(a_out_val), .out_x(a_out_x), .out_y(a_out_y),
        .out_match(a_out_match)
`ifdef HSV_SCHED_MATCH_COUNT_EN
        , .frame_match_cnt(a_fmc), .frame_end(a_fend)
`endif
    );

    hsv_conv_sched #(.WIDTH(4), .HEIGHT(2), .HUE_LO(7'd120), .HUE_HI(7'd5)) dut_b (
        .clk(clk), .res(res), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .pix_ready(b_pix_ready),
        .conv_res(b_conv_res), .conv_read(b_conv_read), .conv_data(b_conv_data),
        .conv_hue(conv_hue), .conv_sat(conv_sat), .conv_val(conv_val),
        .conv_hue_invalid(conv_hue_invalid), .conv_done(conv_done),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_hue(b_out_hue),
        .out_sat(b_out_sat), .out_val(b_out_val), .out_x(b_out_x), .out_y(b_out_y),
        .out_match(b_out_match)
`ifdef HSV_SCHED_MATCH_COUNT_EN
        , .frame_match_cnt(b_fmc), .frame_end(b_fend)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;
    int ax = 0, ay = 0, bx = 0, by = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total_cnt++;
        assert (obs === exp_v) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Coordinate rules: sof restarts at origin, eol or last column starts a new line, y saturates.
    task automatic coord_step(input int w, input int h, input logic sof, input logic eol,
                              inout int cx, inout int cy, output int px, output int py);
        px = sof ? 0 : cx;
        py = sof ? 0 : cy;
        if (eol || px == w - 1) begin
            cx = 0;
            cy = (py + 1 > h - 1) ? h - 1 : py + 1;
        end else begin
            cx = px + 1;
            cy = py;
        end
    endtask

    function automatic logic ref_match(input int lo, input int hi, input int hu,
                                       input int s, input int v, input logic inv);
        logic win;
        win = (lo <= hi) ? (hu >= lo && hu <= hi) : (hu >= lo || hu <= hi);
        return !inv && win && s >= 8 && v >= 6;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!a_pix_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, a_pix_ready}, 32'd1);
    endtask

    // One full pixel transaction; done_k is the WAIT cycle index that raises conv_done (-1: never).
    task automatic do_pixel(input logic [15:0] d, input logic sof, input logic eol,
                            input logic [6:0] h, input logic [4:0] s, input logic [4:0] v,
                            input logic inv, input int done_k, input logic stale, input int hold);
        int apx, apy, bpx, bpy, lat, exp_lat;
        logic am, bm;
        coord_step(640, 480, sof, eol, ax, ay, apx, apy);
        coord_step(4, 2, sof, eol, bx, by, bpx, bpy);
        am = ref_match(0, 10, int'(h), int'(s), int'(v), inv);
        bm = ref_match(120, 5, int'(h), int'(s), int'(v), inv);
        exp_lat = (done_k >= 0 && done_k < CONV_LAT - 1) ? done_k + 2 : CONV_LAT + 1;

        @(negedge clk);
        wait_ready("pix_ready_idle");
        pix_valid = 1'b1;
        pix_data  = d;
        pix_sof   = sof;
        pix_eol   = eol;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        pix_eol   = 1'b0;
        @(negedge clk);
        chk("issue", {14'd0, a_conv_read, b_conv_read, a_conv_data}, {14'd0, 2'b11, d});
        conv_hue = h;
        conv_sat = s;
        conv_val = v;
        conv_hue_invalid = inv;
        conv_done = stale;
        lat = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (a_out_valid) begin
                lat = c;
                break;
            end
            conv_done = (c - 1 == done_k);
        end
        conv_done = 1'b0;
        conv_hue = ~h;
        conv_sat = ~s;
        conv_val = ~v;
        conv_hue_invalid = ~inv;
        chk("latency", 32'(lat), 32'(exp_lat));
        chk("b_valid", {31'd0, b_out_valid}, 32'd1);
        chk("a_hsv", {15'd0, a_out_hue, a_out_sat, a_out_val}, {15'd0, h, s, v});
        chk("b_hsv", {15'd0, b_out_hue, b_out_sat, b_out_val}, {15'd0, h, s, v});
        chk("a_xy", {13'd0, a_out_x, a_out_y}, {13'd0, 10'(apx), 9'(apy)});
        chk("b_xy", {13'd0, b_out_x, b_out_y}, {13'd0, 10'(bpx), 9'(bpy)});
        chk("a_match", {31'd0, a_out_match}, {31'd0, am});
        chk("b_match", {31'd0, b_out_match}, {31'd0, bm});
        $display("pixel %h sof=%0d eol=%0d hue=%0d sat=%0d val=%0d inv=%0d -> A(%0d,%0d,m=%0d) B(%0d,%0d,m=%0d) lat=%0d",
                 d, sof, eol, h, s, v, inv, a_out_x, a_out_y, a_out_match,
                 b_out_x, b_out_y, b_out_match, lat);

        // Camera keeps offering a pixel while the result is held; nothing may move.
        pix_valid = (hold > 0);
        pix_data  = ~d;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold", {a_out_valid, a_pix_ready, a_conv_read, 1'b0, a_out_hue, a_out_sat,
                         a_out_x, 6'd0},
                        {1'b1, 1'b0, 1'b0, 1'b0, h, s, 10'(apx), 6'd0});
            chk("hold_data", {16'd0, a_conv_data}, {16'd0, d});
        end
        pix_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("release", {30'd0, a_out_valid, a_pix_ready}, 32'b01);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset held low for three cycles.
        repeat (3) @(negedge clk);
        chk("rst_outs", {a_out_valid, a_conv_read, a_pix_ready, a_out_match, a_out_hue,
                         a_out_sat, a_out_val, a_out_x, 2'd0},
                        32'd0);
        chk("rst_misc", {7'd0, a_out_y, a_conv_data}, 32'd0);
        chk("rst_conv_res", {30'd0, a_conv_res, b_conv_res}, 32'b11);
        res = 1'b1;
        #1;
        chk("rel_conv_res", {30'd0, a_conv_res, a_pix_ready}, 32'b10);
        @(negedge clk);
        chk("rel_ready", {30'd0, a_conv_res, a_pix_ready}, 32'b01);
        $display("reset released: conv_res=%0d pix_ready=%0d", a_conv_res, a_pix_ready);

        // Pure red, sof, full-latency conversion.
        do_pixel(16'h7C00, 1'b1, 1'b0, 7'd0, 5'd31, 5'd31, 1'b0, -1, 1'b0, 0);
        // Grey with early completion on WAIT cycle 1.
        do_pixel(16'h4210, 1'b0, 1'b0, 7'd0, 5'd0, 5'd16, 1'b1, 1, 1'b0, 0);
        // Hue window boundaries for both instances.
        do_pixel(16'h0001, 1'b0, 1'b0, 7'd125, 5'd20, 5'd20, 1'b0, -1, 1'b0, 0);
        do_pixel(16'h0002, 1'b0, 1'b0, 7'd60, 5'd20, 5'd20, 1'b0, -1, 1'b0, 0);
        do_pixel(16'h0003, 1'b0, 1'b0, 7'd5, 5'd7, 5'd20, 1'b0, -1, 1'b0, 0);
        do_pixel(16'h0004, 1'b0, 1'b0, 7'd10, 5'd8, 5'd6, 1'b0, 0, 1'b0, 0);
        do_pixel(16'h0005, 1'b0, 1'b0, 7'd120, 5'd8, 5'd6, 1'b0, 2, 1'b0, 0);
        do_pixel(16'h0006, 1'b0, 1'b0, 7'd3, 5'd31, 5'd5, 1'b0, -1, 1'b0, 0);
        // Stale done during ISSUE must be ignored; result held under backpressure.
        do_pixel(16'h1357, 1'b0, 1'b0, 7'd8, 5'd12, 5'd12, 1'b0, -1, 1'b1, 5);

        // Coordinate stream: sof, nine plain pixels, then eol, then one more.
        for (int i = 0; i < 12; i++) begin
            do_pixel(16'(i), (i == 0), (i == 10), 7'(i * 11), 5'd15, 5'd15, 1'b0, -1, 1'b0, 0);
        end

        // Randomised traffic.
        for (int i = 0; i < 24; i++) begin
            do_pixel(16'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 5) == 0),
                     7'($urandom_range(0, 127)), 5'($urandom), 5'($urandom),
                     ($urandom_range(0, 7) == 0), int'($urandom_range(0, 4)) - 1,
                     ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of WAIT.
        @(negedge clk);
        wait_ready("pix_ready_pre_rst");
        pix_valid = 1'b1;
        pix_data  = 16'h2AAA;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        #1;
        chk("midrst_outs", {a_out_valid, a_conv_read, a_pix_ready, a_out_match, a_out_hue,
                            a_out_sat, a_out_val, a_out_x, 2'd0},
                           32'd0);
        chk("midrst_misc", {6'd0, a_conv_res, a_out_y, a_conv_data}, {6'd0, 1'b1, 25'd0});
        repeat (2) @(negedge clk);
        chk("midrst_hold", {29'd0, a_out_valid, b_out_valid, b_conv_read}, 32'd0);
        res = 1'b1;
        ax = 0; ay = 0; bx = 0; by = 0;
        $display("mid-WAIT reset applied and released");
        do_pixel(16'h0BAD, 1'b0, 1'b0, 7'd2, 5'd9, 5'd9, 1'b0, -1, 1'b0, 1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
